data_mem_ws: RTL and testbench

- Parametrised successor to the 32-bit data memory in the MIPS pipeline's MEM stage.
- Adds byte addressing, byte/half/word loads and stores with sign or zero extension, and alignment and range error detection.
- Adds a configurable number of wait states with a Stall output, so the pipeline can model slower memory.
- Accepts one access at a time; the hazard/stall logic uses Stall to freeze the pipeline.

---
 rtl/data_mem_ws.sv | 170 +++++++++++++++++
 tb/tb_data_mem_ws.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ws.sv
// Byte-addressed 32-bit data memory for the MEM stage with byte/half/word
// access, sign/zero-extended loads, error detection and optional wait states.
module data_mem_ws #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Adr,
    input  logic [31:0] Wrd,
    input  logic        MemWr,
    input  logic        MemR,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    output logic [31:0] Rd,
    output logic        Ready,
    output logic        Stall,
    output logic        AdrErr
);
    localparam int ADDR_BITS = $clog2(DEPTH);
    localparam int AW        = ADDR_BITS + 2;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [AW-1:0]   lat_adr_q, lat_adr_d;
    logic [31:0]     lat_wrd_q, lat_wrd_d;
    logic [1:0]      lat_size_q, lat_size_d;
    logic            lat_uns_q, lat_uns_d;
    logic            lat_wr_q, lat_wr_d;
    logic [31:0]     rd_q, rd_d;
    logic            ready_q, ready_d;
    logic            adr_err_q, adr_err_d;

    // Storage holds (value XOR word index), so an all-zero power-up state
    // reads back as MEM[i] = i without any initialisation logic.
    logic [31:0]     mem_q [DEPTH];

    logic            idle, req, err, legal, commit, mem_we;
    logic [AW-1:0]   acc_adr;
    logic [31:0]     acc_wrd;
    logic [1:0]      acc_size;
    logic            acc_uns, acc_wr;
    logic [ADDR_BITS-1:0] widx;
    logic [31:0]     cur_word, new_word, shifted, load_val, mem_wdata;

    always_comb begin
        idle  = (state_q == S_IDLE);
        req   = MemWr | MemR;
        err   = (Size == 2'b11) ||
                (Size == 2'b01 && Adr[0]) ||
                (Size == 2'b10 && Adr[1:0] != 2'b00) ||
                (Adr[31:AW] != '0);
        legal = req & ~err;

        if (state_q == S_WAIT) begin
            acc_adr  = lat_adr_q;
            acc_wrd  = lat_wrd_q;
            acc_size = lat_size_q;
            acc_uns  = lat_uns_q;
            acc_wr   = lat_wr_q;
        end else begin
            acc_adr  = Adr[AW-1:0];
            acc_wrd  = Wrd;
            acc_size = Size;
            acc_uns  = Unsigned;
            acc_wr   = MemWr;
        end

        commit = (WAIT_STATES == 0) ? (idle && legal)
                                    : (state_q == S_WAIT && cnt_q == 3'd1);
        // Low in the last WAIT cycle so the pipeline advances on the commit edge.
        Stall  = (idle && legal && (WAIT_STATES != 0)) ||
                 (state_q == S_WAIT && cnt_q > 3'd1);
    end

    always_comb begin
        widx     = acc_adr[AW-1:2];
        cur_word = mem_q[widx] ^ 32'(widx);
        shifted  = cur_word >> {acc_adr[1:0], 3'b000};

        new_word = cur_word;
        case (acc_size)
            2'b00:   new_word[{acc_adr[1:0], 3'b000} +: 8]  = acc_wrd[7:0];
            2'b01:   new_word[{acc_adr[1], 4'b0000} +: 16]  = acc_wrd[15:0];
            default: new_word = acc_wrd;
        endcase

        case (acc_size)
            2'b00:   load_val = acc_uns ? {24'b0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = acc_uns ? {16'b0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = cur_word;
        endcase

        mem_we    = commit & acc_wr & ~Rst;
        mem_wdata = new_word ^ 32'(widx);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_adr_d  = lat_adr_q;
        lat_wrd_d  = lat_wrd_q;
        lat_size_d = lat_size_q;
        lat_uns_d  = lat_uns_q;
        lat_wr_d   = lat_wr_q;
        rd_d       = rd_q;
        ready_d    = commit;
        adr_err_d  = idle & req & err;

        if (commit && !acc_wr)
            rd_d = load_val;

        case (state_q)
            S_IDLE: begin
                if (legal && (WAIT_STATES != 0)) begin
                    state_d    = S_WAIT;
                    cnt_d      = 3'(WAIT_STATES);
                    lat_adr_d  = Adr[AW-1:0];
                    lat_wrd_d  = Wrd;
                    lat_size_d = Size;
                    lat_uns_d  = Unsigned;
                    lat_wr_d   = MemWr;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            rd_q      <= 32'd0;
            ready_q   <= 1'b0;
            adr_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            ready_q   <= ready_d;
            adr_err_q <= adr_err_d;
        end
    end

    always_ff @(posedge Clk) begin
        lat_adr_q  <= lat_adr_d;
        lat_wrd_q  <= lat_wrd_d;
        lat_size_q <= lat_size_d;
        lat_uns_q  <= lat_uns_d;
        lat_wr_q   <= lat_wr_d;
    end

    always_ff @(posedge Clk) begin
        if (mem_we)
            mem_q[widx] <= mem_wdata;
    end

    assign Rd     = rd_q;
    assign Ready  = ready_q;
    assign AdrErr = adr_err_q;
endmodule

// File: tb/tb_data_mem_ws.sv
// Scoreboard bench for data_mem_ws: one instance without wait states, one with
// three, both checked against a byte-array reference memory.
module tb_data_mem_ws;
    localparam int DEPTH = 256;
    localparam int NB    = DEPTH * 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i  [2];
    logic [31:0] adr_i  [2];
    logic [31:0] wrd_i  [2];
    logic        wr_i   [2];
    logic        rdq_i  [2];
    logic [1:0]  size_i [2];
    logic        uns_i  [2];
    logic [31:0] rd_o   [2];
    logic        ready_o[2];
    logic        stall_o[2];
    logic        err_o  [2];

    data_mem_ws #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .Clk(clk), .Rst(rst_i[0]), .Adr(adr_i[0]), .Wrd(wrd_i[0]),
        .MemWr(wr_i[0]), .MemR(rdq_i[0]), .Size(size_i[0]), .Unsigned(uns_i[0]),
        .Rd(rd_o[0]), .Ready(ready_o[0]), .Stall(stall_o[0]), .AdrErr(err_o[0]));

    data_mem_ws #(.DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
        .Clk(clk), .Rst(rst_i[1]), .Adr(adr_i[1]), .Wrd(wrd_i[1]),
        .MemWr(wr_i[1]), .MemR(rdq_i[1]), .Size(size_i[1]), .Unsigned(uns_i[1]),
        .Rd(rd_o[1]), .Ready(ready_o[1]), .Stall(stall_o[1]), .AdrErr(err_o[1]));

    typedef struct {
        bit          err;
        logic [31:0] rd;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [7:0]  ref_b [2][NB];
    logic [31:0] ref_rd[2];
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic int ws(int u);
        return (u == 0) ? 0 : 3;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit ref_err(logic [31:0] a, logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
               (sz == 2'd2 && a[1:0] != 2'd0) || (a >= 32'(NB));
    endfunction

    function automatic logic [31:0] ref_load(int u, logic [31:0] a, logic [1:0] sz, bit un);
        logic [31:0] v;
        int          n;
        v = 32'd0;
        n = 1 << sz;
        for (int i = 0; i < n; i++)
            v = v | (32'(ref_b[u][a + i]) << (8 * i));
        if (!un && sz == 2'd0) v = {{24{v[7]}}, v[7:0]};
        if (!un && sz == 2'd1) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    // Called half a nanosecond-ish after a posedge; returns #1 after the
    // edge that completed the access.
    task automatic access(int u, bit w, bit r, logic [1:0] sz, bit un,
                          logic [31:0] a, logic [31:0] d);
        exp_t e;
        bit   bad, s, done;
        int   nst;
        bad = ref_err(a, sz);
        if (!bad) begin
            if (w) begin
                for (int i = 0; i < (1 << sz); i++)
                    ref_b[u][a + i] = 8'(d >> (8 * i));
            end else begin
                ref_rd[u] = ref_load(u, a, sz, un);
            end
        end
        e.err = bad;
        e.rd  = ref_rd[u];
        if (u == 0) q0.push_back(e); else q1.push_back(e);

        adr_i[u] = a; wrd_i[u] = d; size_i[u] = sz; uns_i[u] = un;
        wr_i[u] = w; rdq_i[u] = r;
        nst = 0; done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            s = stall_o[u];
            if (s) nst++;
            @(posedge clk);
            if (!s) done = 1;
        end
        #1;
        wr_i[u] = 1'b0; rdq_i[u] = 1'b0;
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL stall_timeout u%0d adr %h: stall still high after 20 cycles", u, a);
        end
        chk($sformatf("stall_cycles_u%0d_adr_%h", u, a), 32'(nst), bad ? 32'd0 : 32'(ws(u)));
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mon(int u);
        exp_t e;
        bit   have;
        if (ready_o[u] || err_o[u]) begin
            have = (u == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (!have) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_pulse u%0d: ready=%b adrerr=%b rd=%h, nothing pending",
                         u, ready_o[u], err_o[u], rd_o[u]);
            end else begin
                e = (u == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("pulse_ready_adrerr_u%0d", u),
                    {30'd0, ready_o[u], err_o[u]}, {30'd0, !e.err, e.err});
                chk($sformatf("pulse_rd_u%0d", u), rd_o[u], e.rd);
            end
        end
    endtask

    always @(negedge clk) mon(0);
    always @(negedge clk) mon(1);

    task automatic rand_run(int u, int n);
        logic [31:0] a, d;
        logic [1:0]  sz;
        int          r, kind;
        for (int i = 0; i < n; i++) begin
            r  = $urandom_range(0, 19);
            sz = (r == 0) ? 2'd3 : 2'(r % 3);
            r  = $urandom_range(0, 9);
            if (r == 0) a = $urandom;
            else begin
                a = $urandom_range(0, NB - 1);
                if (r > 2 && sz == 2'd1) a[0] = 1'b0;
                if (r > 2 && sz == 2'd2) a[1:0] = 2'b00;
            end
            kind = $urandom_range(0, 2);
            d    = $urandom;
            access(u, kind != 0, kind != 1, sz, 1'($urandom_range(0, 1)), a, d);
            r = $urandom_range(0, 2);
            if (r != 0) idle(r);
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_i[u] = 1'b1; adr_i[u] = '0; wrd_i[u] = '0; wr_i[u] = 1'b0;
            rdq_i[u] = 1'b0; size_i[u] = '0; uns_i[u] = 1'b0;
            ref_rd[u] = 32'd0;
            for (int w = 0; w < DEPTH; w++)
                for (int k = 0; k < 4; k++)
                    ref_b[u][4 * w + k] = 8'(w >> (8 * k));
        end
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("reset_rd_u%0d", u), rd_o[u], 32'd0);
            chk($sformatf("reset_ready_u%0d", u), 32'(ready_o[u]), 32'd0);
            chk($sformatf("reset_stall_u%0d", u), 32'(stall_o[u]), 32'd0);
            chk($sformatf("reset_adrerr_u%0d", u), 32'(err_o[u]), 32'd0);
        end
        rst_i[0] = 1'b0; rst_i[1] = 1'b0;
        idle(1);

        // No wait states: directed loads/stores and error cases
        access(0, 0, 1, 2'd2, 0, 32'h10, 0);          chk("lw_10", rd_o[0], 32'h00000004);
        access(0, 1, 0, 2'd0, 0, 32'h21, 32'hAB);
        access(0, 0, 1, 2'd2, 0, 32'h20, 0);          chk("lw_20_after_sb", rd_o[0], 32'h0000AB08);
        access(0, 0, 1, 2'd0, 0, 32'h21, 0);          chk("lb_21_signed", rd_o[0], 32'hFFFFFFAB);
        access(0, 0, 1, 2'd0, 1, 32'h21, 0);          chk("lbu_21", rd_o[0], 32'h000000AB);
        access(0, 1, 0, 2'd1, 0, 32'h26, 32'h8001);
        access(0, 0, 1, 2'd1, 0, 32'h26, 0);          chk("lh_26_signed", rd_o[0], 32'hFFFF8001);
        access(0, 0, 1, 2'd2, 0, 32'h24, 0);          chk("lw_24", rd_o[0], 32'h80010009);
        access(0, 0, 1, 2'd2, 0, 32'h13, 0);
        access(0, 0, 1, 2'd1, 0, 32'h11, 0);
        access(0, 0, 1, 2'd3, 0, 32'h20, 0);
        access(0, 0, 1, 2'd2, 0, 32'h400, 0);
        access(0, 1, 0, 2'd2, 0, 32'h400, 32'h55);    chk("rd_kept_after_errors", rd_o[0], 32'h80010009);
        access(0, 1, 1, 2'd2, 0, 32'h30, 32'h12345678);
        chk("rd_kept_on_wr_and_rd", rd_o[0], 32'h80010009);
        access(0, 0, 1, 2'd2, 0, 32'h30, 0);          chk("lw_30", rd_o[0], 32'h12345678);
        idle(2);

        // Three wait states: back-to-back loads, abort by reset, combined request
        access(1, 0, 1, 2'd2, 0, 32'h10, 0);          chk("ws3_lw_10", rd_o[1], 32'h00000004);
        access(1, 0, 1, 2'd2, 0, 32'h14, 0);          chk("ws3_lw_14", rd_o[1], 32'h00000005);
        idle(2);
        adr_i[1] = 32'h10; wrd_i[1] = 32'hDEADBEEF; size_i[1] = 2'd2; wr_i[1] = 1'b1;
        @(posedge clk); #1;
        chk("ws3_stall_in_wait", 32'(stall_o[1]), 32'd1);
        rst_i[1] = 1'b1; wr_i[1] = 1'b0;
        @(posedge clk); #1;
        rst_i[1] = 1'b0;
        ref_rd[1] = 32'd0;
        chk("ws3_stall_after_reset", 32'(stall_o[1]), 32'd0);
        chk("ws3_ready_after_reset", 32'(ready_o[1]), 32'd0);
        chk("ws3_rd_after_reset", rd_o[1], 32'd0);
        idle(1);
        access(1, 0, 1, 2'd2, 0, 32'h10, 0);          chk("ws3_lw_10_no_write", rd_o[1], 32'h00000004);
        access(1, 1, 1, 2'd2, 0, 32'h30, 32'h12345678);
        access(1, 0, 1, 2'd2, 0, 32'h30, 0);          chk("ws3_lw_30", rd_o[1], 32'h12345678);
        idle(2);

        rand_run(0, 200);
        idle(2);
        rand_run(1, 150);
        idle(3);

        chk("pending_u0", 32'(q0.size()), 32'd0);
        chk("pending_u1", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
